signed_divider_seq: RTL and testbench

- Sequential signed divider; the inverse operation of the team's signed 4x4 -> 8-bit multiplier.
- Takes an 8-bit two's-complement dividend and a 4-bit two's-complement divisor.
- Returns an 8-bit quotient and a 4-bit remainder using truncating (round-toward-zero) division.
- Iterative restoring algorithm, one quotient bit per clock, start/busy/done handshake.
- Used to recover operands from products in the arithmetic test chain, and as a standalone arithmetic block.

---
 rtl/signed_divider_seq.sv | 144 ++++++++++++++
 tb/tb_signed_divider_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_seq.sv
// rtl/signed_divider_seq.sv - sequential signed restoring divider, one quotient bit per clock
// IDLE latches magnitudes and signs, CALC runs DW restoring steps, SIGN applies signs and flags.
module signed_divider_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_prem;
  logic [CW-1:0] r_cnt;
  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_dz;
  logic          r_ovf;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  logic          r_div_zero;
  logic          r_overflow;

  logic [DW-1:0] w_abs_dvd;
  logic [VW-1:0] w_abs_dvs;
  logic          w_ovf_in;
  logic [VW:0]   w_shift;
  logic          w_ge;
  logic [VW-1:0] w_trial;

  assign w_abs_dvd = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
  assign w_abs_dvs = divisor[VW-1]  ? (~divisor + 1'b1)  : divisor;
  assign w_ovf_in  = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == {VW{1'b1}});

  // The stored partial remainder is always below |divisor| <= 2^(VW-1), so VW bits hold it
  // and only the freshly shifted value needs the extra bit.
  assign w_shift = {r_prem, r_dvd[DW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_trial = w_shift[VW-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(DW - 1)) w_next = S_SIGN;
      S_SIGN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd    <= w_abs_dvd;
            r_dvs    <= w_abs_dvs;
            r_sign_q <= dividend[DW-1] ^ divisor[VW-1];
            r_sign_r <= dividend[DW-1];
            r_dz     <= (divisor == '0);
            r_ovf    <= w_ovf_in;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_CALC: begin
          r_prem <= w_ge ? w_trial : w_shift[VW-1:0];
          r_dvd  <= {r_dvd[DW-2:0], w_ge};
          r_cnt  <= r_cnt + 1'b1;
        end
        S_SIGN: begin
          // -128 / -1 needs no special case: the magnitude 128 wraps to 8'h80 on its own.
          if (r_dz) begin
            r_quot <= '0;
            r_rem  <= '0;
          end else begin
            r_quot <= r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
            r_rem  <= r_sign_r ? (~r_prem + 1'b1) : r_prem;
          end
          r_div_zero <= r_dz;
          r_overflow <= r_ovf;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_div_zero;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_signed_divider_seq.sv
// tb/tb_signed_divider_seq.sv - self-checking bench for signed_divider_seq
// Directed cases, handshake corners, random and exhaustive operands against an arithmetic model.
module tb_signed_divider_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int total;
  int bad;

  signed_divider_seq #(.DW(8), .VW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {quotient, remainder, div_by_zero, overflow}.
  function automatic logic [13:0] model(input logic [7:0] a, input logic [3:0] b);
    int sa;
    int sb;
    int q;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {8'h00, 4'h0, 1'b1, 1'b0};
    if (sa == -128 && sb == -1) return {8'h80, 4'h0, 1'b0, 1'b1};
    q = sa / sb;
    r = sa % sb;
    return {q[7:0], r[3:0], 2'b00};
  endfunction

  task automatic check_res(input string tag, input logic [13:0] exp);
    total++;
    assert ({quotient, remainder, div_by_zero, overflow} === exp) else begin
      bad++;
      $error("FAIL %s: got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b", tag,
             quotient, remainder, div_by_zero, overflow, exp[13:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Called at a negedge; the following posedge accepts, returns at the negedge after it.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // cyc0 counts negedges already seen since the accepting edge; done must appear at the 10th.
  task automatic wait_done(input string tag, input int cyc0);
    int cyc;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    assert (done === 1'b1 && cyc == 10) else begin
      bad++;
      $error("FAIL %s latency: got done=%b after %0d cycles expected done=1 after 10", tag, done, cyc);
    end
  endtask

  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++;
    assert (seen == 0) else begin
      bad++;
      $error("FAIL %s: got %0d spurious done pulses expected 0", tag, seen);
    end
  endtask

  task automatic op_const(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [13:0] exp);
    launch(a, b);
    wait_done(tag, 1);
    check_res(tag, exp);
  endtask

  task automatic op_model(input string tag, input logic [7:0] a, input logic [3:0] b);
    launch(a, b);
    wait_done(tag, 1);
    check_res(tag, model(a, b));
  endtask

  initial begin
    logic [7:0] ba [6];
    logic [3:0] bb [6];
    logic [11:0] idx;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    total++;
    assert ({busy, done, quotient, remainder, div_by_zero, overflow} === 16'h0) else begin
      bad++;
      $error("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ov=%b expected all 0",
             busy, done, quotient, remainder, div_by_zero, overflow);
    end
    reset = 1'b0;
    @(negedge clk);

    launch(8'd100, 4'd7);
    total++;
    assert (busy === 1'b1) else begin
      bad++;
      $error("FAIL busy_after_start: got %b expected 1", busy);
    end
    wait_done("100/7", 1);
    check_res("100/7", {8'h0E, 4'h2, 2'b00});
    @(negedge clk);
    total++;
    assert (done === 1'b0 && busy === 1'b0) else begin
      bad++;
      $error("FAIL done_pulse: got done=%b busy=%b expected done=0 busy=0", done, busy);
    end
    check_res("100/7_hold", {8'h0E, 4'h2, 2'b00});

    op_const("-100/7",   8'h9C, 4'h7, {8'hF2, 4'hE, 2'b00});
    op_const("100/-8",   8'd100, 4'h8, {8'hF4, 4'h4, 2'b00});
    op_const("-128/-1",  8'h80, 4'hF, {8'h80, 4'h0, 2'b01});
    op_const("55/0",     8'd55, 4'h0, {8'h00, 4'h0, 2'b10});
    op_const("-128/-8",  8'h80, 4'h8, {8'h10, 4'h0, 2'b00});
    op_const("127/-8",   8'h7F, 4'h8, {8'hF1, 4'h7, 2'b00});
    op_const("-128/7",   8'h80, 4'h7, {8'hEE, 4'hE, 2'b00});
    op_const("-3/7",     8'hFD, 4'h7, {8'h00, 4'hD, 2'b00});

    // Re-pulse of start three cycles into the operation must be ignored.
    launch(8'd100, 4'd7);
    @(negedge clk);
    @(negedge clk);
    dividend = 8'h11;
    divisor  = 4'h3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done("repulse", 4);
    check_res("repulse", {8'h0E, 4'h2, 2'b00});
    no_done("repulse_single", 15);

    // Reset during CALC aborts the operation.
    launch(8'd100, 4'd7);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    assert ({busy, done, quotient, remainder, div_by_zero, overflow} === 16'h0) else begin
      bad++;
      $error("FAIL reset_abort: got busy=%b done=%b q=%h r=%h dz=%b ov=%b expected all 0",
             busy, done, quotient, remainder, div_by_zero, overflow);
    end
    no_done("reset_abort_nodone", 14);
    op_const("after_reset", 8'h9C, 4'h7, {8'hF2, 4'hE, 2'b00});

    // start held high: one result every 10 cycles, each from its accepting operands.
    ba = '{8'd100, 8'h80, 8'h9C, 8'd55, 8'h7F, 8'h01};
    bb = '{4'd7, 4'hF, 4'h8, 4'h0, 4'h3, 4'hF};
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dividend = ba[k];
      divisor  = bb[k];
      @(negedge clk);
      wait_done("held_start", 1);
      check_res("held_start", model(ba[k], bb[k]));
    end
    start = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 300; k++) begin
      op_model("random", 8'($urandom), 4'($urandom));
    end

    for (int i = 0; i < 4096; i++) begin
      idx = 12'(i);
      op_model("exhaustive", idx[11:4], idx[3:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
